alu_result_tx: RTL and testbench
================================

# alu_result_tx

Serial result transmitter for the ALU board. It latches the ALU result and carry on a send request and returns them to the host over a UART TX line (8N1, LSB first). The frames go in this order: a result byte, then a flags byte. It is the return path of the operand-load datapath: operands and opcode enter from switches, and results leave through this block.

## Interface
Parameters:
- NB_DATA, default 8: result width and data bits per frame.
- CLKS_PER_BIT, default 5208: clock cycles per UART bit (50 MHz / 9600 baud). Minimum 2.

Ports:
- i_clk, in, 1: system clock. Single clock domain.
- i_reset, in, 1: synchronous, active-high reset.
- i_res, in, NB_DATA: ALU result.
- i_carry, in, 1: ALU carry.
- i_send, in, 1: transmit request. Level-sampled; accepted only in IDLE.
- o_tx, out, 1: UART serial line. Idles high. Registered.
- o_busy, out, 1: transaction in progress. Registered.
- o_done, out, 1: one-cycle pulse when the transaction ends. Registered.

## Operation
- Reset values: o_tx=1, o_busy=0, o_done=0, state IDLE, all counters 0, latched data 0.
- Reset acts mid-transaction. The next edge forces IDLE and o_tx=1. The partial frame is abandoned. No o_done is issued.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE with i_send=1: latch the two bytes and go to START.
    - byte0 = i_res.
    - byte1 = {zeros, zero_flag, i_carry}: bit0 is carry, bit1 is (i_res == 0), remaining bits are 0.
    - Set byte_sel=0 and o_busy=1.
  - START: o_tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx=0.
  - DATA: o_tx = current byte[bit_idx] for CLKS_PER_BIT cycles. bit_idx counts 0 to NB_DATA-1. After the last bit, go to STOP.
  - STOP: o_tx=1 for CLKS_PER_BIT cycles. Then:
    - If byte_sel=0: set byte_sel=1 and go to START with no idle gap.
    - Otherwise: go to IDLE, set o_busy=0, and pulse o_done.
- Timing uses a baud counter (ceil(log2(CLKS_PER_BIT)) bits). It counts 0 to CLKS_PER_BIT-1 and clears on every bit boundary and on accept.
- i_send is ignored while o_busy=1. Inputs i_res and i_carry are not sampled after accept, so the latched values are transmitted even if the inputs change.
- i_send held high continuously: a new transaction is accepted in the IDLE cycle in which o_done pulses.

## Timing
- Cycle numbering: cycle 0 is the clock edge that accepts i_send. Let F = (NB_DATA+2)·CLKS_PER_BIT.
- The start bit of frame 0 appears on o_tx in cycles 1 to CLKS_PER_BIT.
- Frame 0 occupies cycles 1 to F. Frame 1 occupies cycles F+1 to 2F.
- o_busy is high in cycles 1 to 2F.
- In cycle 2F+1: o_done=1, o_busy=0, o_tx=1.
- Latency from accept to the first o_tx change is 1 cycle.
- Each bit holds exactly CLKS_PER_BIT cycles, with no jitter between bits or between frames.
- o_done lasts exactly one cycle per completed transaction.

## Test plan
All scenarios use CLKS_PER_BIT=4 and NB_DATA=8, so F=40.
1. Basic send: i_res=0x5A, i_carry=1, pulse i_send.
   - o_tx per 4-cycle bit: 0, 0,1,0,1,1,0,1,0, 1, then 0, 1,0,0,0,0,0,0,0, 1.
   - o_busy high in cycles 1 to 80. o_done high only in cycle 81.
2. Zero flag: i_res=0x00, i_carry=0 → byte0=0x00, byte1=0x02. A UART monitor decodes 0x00, 0x02.
3. Busy protection:
   - Start a send with 0x33/carry 0.
   - In cycle 20, pulse i_send and change i_res to 0xFF.
   - Required: the monitor decodes only 0x33, 0x00, and o_done pulses exactly once.
4. Back-to-back:
   - Hold i_send=1 with i_res=0x81, i_carry=0.
   - The second transaction is accepted in cycle 81 and its start bit begins in cycle 82.
   - The monitor decodes 0x81,0x00,0x81,0x00.
5. Reset mid-frame:
   - Assert i_reset in cycle 15.
   - From cycle 16: o_tx=1, o_busy=0, and o_done is never asserted.
   - A subsequent send of 0xC3 decodes correctly.
6. Reset state: after power-up reset with i_send=0 for 100 cycles, o_tx=1, o_busy=0, and o_done=0 throughout.

Source files
------------

// File: rtl/alu_result_tx_if.sv
`default_nettype none
// ============================================================================
// alu_result_tx_if
// Result/handshake bundle between the ALU core and the serial result
// transmitter. Signal names are given from the transmitter's point of view.
// Revision: 1.0
// ============================================================================
interface alu_result_tx_if #(
  parameter int NB_DATA = 8
);
  logic [NB_DATA-1:0] i_res;
  logic               i_carry;
  logic               i_send;
  logic               o_tx;
  logic               o_busy;
  logic               o_done;

  // Driver of results and send requests (ALU side / testbench)
  modport master (
    output i_res, i_carry, i_send,
    input  o_tx, o_busy, o_done
  );

  // The transmitter itself
  modport slave (
    input  i_res, i_carry, i_send,
    output o_tx, o_busy, o_done
  );
endinterface
`default_nettype wire

// File: rtl/alu_result_tx.sv
`default_nettype none
// ============================================================================
// alu_result_tx
// Latches an ALU result and carry on request and sends two 8N1 UART frames,
// LSB first: the result byte, then a flags byte {0.., zero, carry}.
// Revision: 1.0
// ============================================================================
module alu_result_tx #(
  parameter int NB_DATA      = 8,
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic           i_clk,
  input  logic           i_reset,
  alu_result_tx_if.slave bus
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(NB_DATA - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t               r_state,  w_state_nxt;
  logic [CNT_W-1:0]     r_cnt,    w_cnt_nxt;
  logic [IDX_W-1:0]     r_idx,    w_idx_nxt;
  logic                 r_sel,    w_sel_nxt;
  logic [NB_DATA-1:0]   r_byte0,  w_byte0_nxt;
  logic [NB_DATA-1:0]   r_byte1,  w_byte1_nxt;
  logic [NB_DATA-1:0]   w_flags;
  logic [NB_DATA-1:0]   w_cur_byte;
  logic                 w_tick;
  logic                 w_tx_nxt;
  logic                 r_tx;
  logic                 r_busy;
  logic                 r_done;

  assign w_tick     = (r_cnt == C_CNT_LAST);
  assign w_cur_byte = r_sel ? r_byte1 : r_byte0;

  // Next-state, counters, latched bytes and the line level for the next cycle
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_sel_nxt   = r_sel;
    w_byte0_nxt = r_byte0;
    w_byte1_nxt = r_byte1;
    w_tx_nxt    = 1'b1;
    w_flags     = '0;
    w_flags[0]  = bus.i_carry;
    w_flags[1]  = (bus.i_res == '0);

    case (r_state)
      S_IDLE: begin
        if (bus.i_send) begin
          w_state_nxt = S_START;
          w_cnt_nxt   = '0;
          w_sel_nxt   = 1'b0;
          w_byte0_nxt = bus.i_res;
          w_byte1_nxt = w_flags;
        end
      end
      S_START: begin
        w_tx_nxt = 1'b0;
        if (w_tick) begin
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
          w_state_nxt = S_DATA;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_DATA: begin
        w_tx_nxt = w_cur_byte[r_idx];
        if (w_tick) begin
          w_cnt_nxt = '0;
          if (r_idx == C_IDX_LAST) begin
            w_state_nxt = S_STOP;
          end else begin
            w_idx_nxt = r_idx + IDX_W'(1);
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_STOP: begin
        w_tx_nxt = 1'b1;
        if (w_tick) begin
          w_cnt_nxt = '0;
          if (!r_sel) begin
            // Flags frame follows immediately, no idle gap on the line
            w_sel_nxt   = 1'b1;
            w_state_nxt = S_START;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs; outputs trail the state by one cycle
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_sel   <= 1'b0;
      r_byte0 <= '0;
      r_byte1 <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_sel   <= w_sel_nxt;
      r_byte0 <= w_byte0_nxt;
      r_byte1 <= w_byte1_nxt;
      r_tx    <= w_tx_nxt;
      r_busy  <= (r_state != S_IDLE);
      // Busy falling while the FSM sits in IDLE marks the end of a transaction
      r_done  <= (r_state == S_IDLE) && r_busy;
    end
  end

  assign bus.o_tx   = r_tx;
  assign bus.o_busy = r_busy;
  assign bus.o_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_alu_result_tx.sv
`default_nettype none
// ============================================================================
// tb_alu_result_tx
// Self-checking bench for alu_result_tx with CLKS_PER_BIT=4, NB_DATA=8.
// A UART monitor decodes o_tx and pops expected bytes from a scoreboard.
// Revision: 1.0
// ============================================================================
module tb_alu_result_tx;

  localparam int NB  = 8;
  localparam int CPB = 4;
  localparam int F   = (NB + 2) * CPB;

  typedef struct {
    logic [7:0] res;
    logic       carry;
    logic [7:0] b0;
    logic [7:0] b1;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [7:0] sb[$];

  // Free-running 100 MHz clock
  always #5 clk = ~clk;

  alu_result_tx_if #(.NB_DATA(NB)) u_if ();

  alu_result_tx #(
    .NB_DATA      (NB),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (u_if)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // UART monitor: t counts cycles since the first low sample of a start bit
  int         m_t = 0;
  logic [7:0] m_byte = 8'h00;
  always @(negedge clk) begin
    if (rst) begin
      m_t = 0;
    end else if (m_t == 0) begin
      if (u_if.o_tx == 1'b0) m_t = 1;
    end else begin
      m_t++;
      if (m_t == 2) begin
        check("uart_start_bit", 32'(u_if.o_tx), 32'(0));
      end else if (m_t > 2 && m_t <= 2 + CPB * NB && ((m_t - 2) % CPB) == 0) begin
        m_byte = {u_if.o_tx, m_byte[7:1]};
      end else if (m_t == 2 + CPB * (NB + 1)) begin
        check("uart_stop_bit", 32'(u_if.o_tx), 32'(1));
        if (sb.size() == 0) begin
          check("uart_unexpected_byte", 32'(m_byte), 32'hFFFF_FFFF);
        end else begin
          check("uart_byte", 32'(m_byte), 32'(sb.pop_front()));
        end
        m_t = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int limit, output int got);
    got = -1;
    for (int k = 1; k <= limit; k++) begin
      tick();
      if (u_if.o_done) begin
        got = k;
        break;
      end
    end
  endtask

  task automatic run_txn(input vec_t v, input string name);
    int got;
    sb.push_back(v.b0);
    sb.push_back(v.b1);
    u_if.i_res   = v.res;
    u_if.i_carry = v.carry;
    u_if.i_send  = 1'b1;
    tick();
    u_if.i_send  = 1'b0;
    wait_done(400, got);
    check({name, "_done_cycle"}, 32'(got), 32'(2 * F + 1));
    repeat (3) tick();
    check({name, "_sb_empty"}, 32'(sb.size()), 32'(0));
  endtask

  // Hard time limit so the run always ends
  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vecs[5];
    int         got;
    int         dcnt;
    int         j;
    int         pos;
    logic [7:0] cur;
    logic       exp_tx;

    vecs[0] = '{res: 8'h00, carry: 1'b0, b0: 8'h00, b1: 8'h02};
    vecs[1] = '{res: 8'h00, carry: 1'b1, b0: 8'h00, b1: 8'h03};
    vecs[2] = '{res: 8'hFF, carry: 1'b1, b0: 8'hFF, b1: 8'h01};
    vecs[3] = '{res: 8'hA5, carry: 1'b0, b0: 8'hA5, b1: 8'h00};
    vecs[4] = '{res: 8'h01, carry: 1'b1, b0: 8'h01, b1: 8'h01};

    u_if.i_res   = 8'h00;
    u_if.i_carry = 1'b0;
    u_if.i_send  = 1'b0;

    // Reset state, then 100 idle cycles
    repeat (3) tick();
    check("reset_outputs", 32'({u_if.o_tx, u_if.o_busy, u_if.o_done}), 32'(3'b100));
    rst = 1'b0;
    for (int k = 0; k < 100; k++) begin
      tick();
      check($sformatf("idle_c%0d", k), 32'({u_if.o_tx, u_if.o_busy, u_if.o_done}), 32'(3'b100));
    end

    // Basic send 0x5A carry 1, cycle-exact line/busy/done
    sb.push_back(8'h5A);
    sb.push_back(8'h01);
    u_if.i_res   = 8'h5A;
    u_if.i_carry = 1'b1;
    u_if.i_send  = 1'b1;
    tick();
    u_if.i_send  = 1'b0;
    for (int k = 1; k <= 2 * F + 1; k++) begin
      tick();
      j   = (k - 1) / CPB;
      pos = j % (NB + 2);
      cur = (j / (NB + 2) == 0) ? 8'h5A : 8'h01;
      if (k > 2 * F)          exp_tx = 1'b1;
      else if (pos == 0)      exp_tx = 1'b0;
      else if (pos == NB + 1) exp_tx = 1'b1;
      else                    exp_tx = cur[pos-1];
      check($sformatf("basic_c%0d", k), 32'({u_if.o_tx, u_if.o_busy, u_if.o_done}),
            32'({exp_tx, (k <= 2 * F), (k == 2 * F + 1)}));
    end
    tick();
    check("basic_done_one_cycle", 32'(u_if.o_done), 32'(0));
    check("basic_sb_empty", 32'(sb.size()), 32'(0));

    // Table of result/carry patterns including the zero flag
    for (int i = 0; i < 5; i++) begin
      run_txn(vecs[i], $sformatf("vec%0d", i));
    end

    // Busy protection: new request and new data mid-transaction are ignored
    sb.push_back(8'h33);
    sb.push_back(8'h00);
    u_if.i_res   = 8'h33;
    u_if.i_carry = 1'b0;
    u_if.i_send  = 1'b1;
    tick();
    u_if.i_send  = 1'b0;
    dcnt = 0;
    for (int k = 1; k <= 200; k++) begin
      tick();
      if (k == 19) begin
        u_if.i_send = 1'b1;
        u_if.i_res  = 8'hFF;
      end
      if (k == 20) u_if.i_send = 1'b0;
      if (u_if.o_done) dcnt++;
    end
    check("busy_done_count", 32'(dcnt), 32'(1));
    check("busy_sb_empty", 32'(sb.size()), 32'(0));

    // Back-to-back with i_send held high
    sb.push_back(8'h81);
    sb.push_back(8'h00);
    sb.push_back(8'h81);
    sb.push_back(8'h00);
    u_if.i_res   = 8'h81;
    u_if.i_carry = 1'b0;
    u_if.i_send  = 1'b1;
    tick();
    dcnt = 0;
    for (int k = 1; k <= 2 * F; k++) begin
      tick();
      if (u_if.o_done) dcnt++;
    end
    check("b2b_early_done", 32'(dcnt), 32'(0));
    tick();
    check("b2b_done_c81", 32'({u_if.o_done, u_if.o_busy, u_if.o_tx}), 32'(3'b101));
    tick();
    check("b2b_start_c82", 32'({u_if.o_busy, u_if.o_tx}), 32'(2'b10));
    u_if.i_send = 1'b0;
    wait_done(400, got);
    check("b2b_second_done", 32'(got + 2 * F + 2), 32'(2 * (2 * F + 1)));
    repeat (3) tick();
    check("b2b_sb_empty", 32'(sb.size()), 32'(0));

    // Reset in the middle of frame 0
    sb.push_back(8'h3C);
    sb.push_back(8'h00);
    u_if.i_res   = 8'h3C;
    u_if.i_carry = 1'b0;
    u_if.i_send  = 1'b1;
    tick();
    u_if.i_send  = 1'b0;
    repeat (15) tick();
    rst = 1'b1;
    sb.delete();
    dcnt = 0;
    for (int k = 16; k < 116; k++) begin
      tick();
      if (u_if.o_done) dcnt++;
      check($sformatf("rst_c%0d", k), 32'({u_if.o_tx, u_if.o_busy}), 32'(2'b10));
      if (k == 18) rst = 1'b0;
    end
    check("rst_no_done", 32'(dcnt), 32'(0));
    run_txn('{res: 8'hC3, carry: 1'b0, b0: 8'hC3, b1: 8'h00}, "post_rst");

    check("final_sb_empty", 32'(sb.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
